uart_tx_fifo: RTL and testbench
===============================

Name: uart_tx_fifo

Overview:
Byte buffer and pacer between the UART receiver's byte strobe (or any byte producer) and the UART transmitter's i_data/i_vld input.
- Absorbs bursts of single-cycle byte strobes into a FIFO.
- Re-issues bytes as single-cycle strobes spaced exactly one UART frame apart.
- Needed because the transmitter has no ready/busy output: a strobe issued mid-frame would be lost.

Parameters:
- FREQ, 50_000_000, clock frequency in Hz; must be an integer multiple of RATE.
- RATE, 2_000_000, UART baud rate in bit/s.
- DEPTH, 16, FIFO depth in bytes; power of two, >= 2.
- GAP_BITS, 1, extra idle bit-times appended after each frame.
- Derived: FRAME = (FREQ/RATE)*(10+GAP_BITS) clock cycles; 275 with the defaults.

Ports:
- clk  in  1  single clock; all logic on the rising edge.
- rst  in  1  synchronous, active-high reset.
- i_data  in  8  byte to enqueue; sampled when i_vld=1.
- i_vld  in  1  single-cycle write strobe.
- o_data  out  8  byte for the transmitter; valid only while o_vld=1.
- o_vld  out  1  single-cycle strobe to the transmitter's i_vld.
- o_full  out  1  count == DEPTH.
- o_empty  out  1  count == 0.
- o_ovf  out  1  sticky overflow flag; set when a write is dropped, cleared only by rst.
- o_count  out  $clog2(DEPTH)+1  bytes currently stored.

Behaviour:
- Interface: one clock, clk; reset is rst, synchronous and active-high. Every register changes only on the rising edge of clk.
- Reset values: o_vld=0, o_data=8'h00, o_count=0, o_empty=1, o_full=0, o_ovf=0, both pointers=0, state=IDLE, pacing counter=0.
- Reset mid-operation: any stored bytes are discarded and a WAIT in progress is aborted. o_vld is 0 in the cycle after rst is sampled high. i_vld is ignored while rst=1.
- FIFO storage:
  - Circular buffer; wr_ptr and rd_ptr are $clog2(DEPTH) bits and wrap modulo DEPTH.
  - o_count is a registered occupancy counter.
- Write rule: when i_vld=1 and o_full=0 (registered value), store i_data and increment wr_ptr.
- Overflow: when i_vld=1 and o_full=1, drop the byte and set o_ovf. This holds even if a pop happens in the same cycle; no bypass.
- Simultaneous push and pop: count is unchanged and both pointers advance.
- State machine:
  - IDLE: if o_empty=0, go to SEND.
  - SEND (one cycle): o_vld=1, o_data = mem[rd_ptr], rd_ptr++, count--, load pacing counter with FRAME-2, go to WAIT.
  - WAIT: decrement the counter. At 0: go to SEND if not empty (checked that cycle), else IDLE.
- o_vld and o_data are registered outputs. o_vld is never high in two consecutive cycles.
- Latency: i_vld in cycle k with the FIFO empty and FSM in IDLE gives o_vld in cycle k+2.
- Spacing: consecutive o_vld pulses are exactly FRAME cycles apart while the FIFO is non-empty.
- A write arriving during WAIT does not shorten the wait.
- Byte order is strictly FIFO. Bytes are not modified.

Decomposition:
- Package uart_pkg holds:
  - BYTE_W = 8
  - FRAME_BITS = 10
  - function frame_cycles(FREQ, RATE, GAP_BITS)
  - FSM state enum {IDLE, SEND, WAIT}
- Sub-module sync_fifo (parameters WIDTH, DEPTH):
  - Inputs: push, pop, wdata.
  - Outputs: rdata (= mem[rd_ptr], combinational), full, empty, count.
  - Owns the overflow-drop rule.
- uart_tx_fifo holds only the pacing FSM, the counter and the o_ovf register.

Test Plan:
- Single byte: reset, idle 5 cycles, i_vld with 8'hA5 in cycle k -> o_vld=1, o_data=8'hA5 in cycle k+2 only; o_empty=1 from then on.
- Burst of 4: bytes 01..04 on consecutive cycles starting k -> o_vld at k+2, k+277, k+552, k+827 with data 01..04 in order; o_count peaks at 3.
- Overflow: 20 back-to-back writes 00..13 with DEPTH=16 -> o_ovf rises on the first dropped write. Output sequence is 00..10 (17 bytes, since the first pop frees a slot before the 18th write arrives); bytes 11..13 are dropped.
- Push and pop together: a write in the same cycle as a SEND when count=1 -> o_count stays 1 and the byte emerges one FRAME later.
- Reset mid-WAIT: rst pulsed 100 cycles after a SEND with 3 bytes queued -> o_count=0, o_vld stays 0, o_ovf=0. A new byte written 3 cycles after rst deasserts appears 2 cycles later.
- Wrap-around: 40 bytes written in paced groups of 5 (never full) -> all 40 emerge in order, no o_ovf, and pointers wrap twice.

Source files
------------

// File: rtl/uart_tx_fifo_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : uart_pkg
//  Description : Shared constants, FSM state encoding and frame-length helper
//                for the UART transmit pacing FIFO.
//  Revision    : 1.0 - initial release
// ============================================================================
package uart_pkg;

    localparam int BYTE_W     = 8;
    localparam int FRAME_BITS = 10;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SEND = 2'd1,
        WAIT = 2'd2
    } state_e;

    // Clock cycles from one transmitter strobe to the next, idle gap included.
    function automatic int frame_cycles(input int freq, input int rate, input int gap_bits);
        return (freq / rate) * (FRAME_BITS + gap_bits);
    endfunction

endpackage
`default_nettype wire

// File: rtl/uart_tx_fifo_fifo.sv
`default_nettype none
// ============================================================================
//  Module      : sync_fifo
//  Description : Single-clock circular FIFO with registered occupancy count;
//                writes into a full FIFO are dropped and flagged on drop_o.
//  Revision    : 1.0 - initial release
// ============================================================================
module sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 16
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push_i,
    input  logic                     pop_i,
    input  logic [WIDTH-1:0]         wdata_i,
    output logic [WIDTH-1:0]         rdata_o,
    output logic                     full_o,
    output logic                     empty_o,
    output logic                     drop_o,
    output logic [$clog2(DEPTH):0]   count_o
);

    localparam int              AW      = $clog2(DEPTH);
    localparam logic [AW-1:0]   C_P_ONE = AW'(1);
    localparam logic [AW:0]     C_C_ONE = (AW+1)'(1);
    localparam logic [AW:0]     C_FULL  = (AW+1)'(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [AW:0]      count_q,  count_d;
    logic             w_do_push;
    logic             w_do_pop;

    assign full_o    = (count_q == C_FULL);
    assign empty_o   = (count_q == '0);
    assign count_o   = count_q;
    assign rdata_o   = mem_q[rd_ptr_q];
    // A full FIFO never takes a write, even if a pop frees a slot this cycle.
    assign w_do_push = push_i & ~full_o;
    assign w_do_pop  = pop_i & ~empty_o;
    assign drop_o    = push_i & full_o;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (w_do_push) begin
            wr_ptr_d = wr_ptr_q + C_P_ONE;
        end
        if (w_do_pop) begin
            rd_ptr_d = rd_ptr_q + C_P_ONE;
        end
        case ({w_do_push, w_do_pop})
            2'b10:   count_d = count_q + C_C_ONE;
            2'b01:   count_d = count_q - C_C_ONE;
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst && w_do_push) begin
            mem_q[wr_ptr_q] <= wdata_i;
        end
    end

endmodule
`default_nettype wire

// File: rtl/uart_tx_fifo.sv
`default_nettype none
// ============================================================================
//  Module      : uart_tx_fifo
//  Description : Buffers byte strobes and re-issues them to a UART transmitter
//                as single-cycle strobes spaced exactly one frame apart.
//  Revision    : 1.0 - initial release
// ============================================================================
module uart_tx_fifo
    import uart_pkg::*;
#(
    parameter int FREQ     = 50_000_000,
    parameter int RATE     = 2_000_000,
    parameter int DEPTH    = 16,
    parameter int GAP_BITS = 1
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [7:0]               i_data,
    input  logic                     i_vld,
    output logic [7:0]               o_data,
    output logic                     o_vld,
    output logic                     o_full,
    output logic                     o_empty,
    output logic                     o_ovf,
    output logic [$clog2(DEPTH):0]   o_count
);

    localparam int                FRAME    = frame_cycles(FREQ, RATE, GAP_BITS);
    localparam int                CNT_W    = $clog2(FRAME);
    localparam logic [CNT_W-1:0]  C_RELOAD = CNT_W'(FRAME - 2);
    localparam logic [CNT_W-1:0]  C_ONE    = CNT_W'(1);
    localparam logic [1:0]        ST_IDLE  = IDLE;
    localparam logic [1:0]        ST_SEND  = SEND;
    localparam logic [1:0]        ST_WAIT  = WAIT;

    logic [1:0]         state_q, state_d;
    logic [CNT_W-1:0]   cnt_q,   cnt_d;
    logic               vld_q,   vld_d;
    logic [BYTE_W-1:0]  data_q,  data_d;
    logic               ovf_q,   ovf_d;
    logic               w_launch;
    logic               w_pop;
    logic               w_drop;
    logic [BYTE_W-1:0]  w_rdata;
    logic               w_empty;

    sync_fifo #(
        .WIDTH (BYTE_W),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .push_i  (i_vld),
        .pop_i   (w_pop),
        .wdata_i (i_data),
        .rdata_o (w_rdata),
        .full_o  (o_full),
        .empty_o (w_empty),
        .drop_o  (w_drop),
        .count_o (o_count)
    );

    // The pop and the output strobe are committed on the edge that enters
    // SEND, so o_vld is high for exactly the cycles spent in SEND.
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        data_d   = data_q;
        vld_d    = 1'b0;
        w_launch = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (!w_empty) begin
                    w_launch = 1'b1;
                end
            end
            ST_SEND: begin
                cnt_d   = C_RELOAD;
                state_d = ST_WAIT;
            end
            ST_WAIT: begin
                if (cnt_q == '0) begin
                    if (!w_empty) begin
                        w_launch = 1'b1;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end else begin
                    cnt_d = cnt_q - C_ONE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
        if (w_launch) begin
            vld_d   = 1'b1;
            data_d  = w_rdata;
            state_d = ST_SEND;
        end
        ovf_d = ovf_q | w_drop;
    end

    assign w_pop = w_launch;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            vld_q   <= 1'b0;
            data_q  <= '0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            vld_q   <= vld_d;
            data_q  <= data_d;
            ovf_q   <= ovf_d;
        end
    end

    assign o_vld   = vld_q;
    assign o_data  = data_q;
    assign o_ovf   = ovf_q;
    assign o_empty = w_empty;

endmodule
`default_nettype wire

// File: tb/tb_uart_tx_fifo.sv
`default_nettype none
// ============================================================================
//  Module      : tb_uart_tx_fifo
//  Description : Directed self-checking bench for uart_tx_fifo (defaults,
//                FRAME = 275 cycles, DEPTH = 16).
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_uart_tx_fifo;

    localparam int FRAME = 275;

    logic       clk;
    logic       rst;
    logic [7:0] i_data;
    logic       i_vld;
    logic [7:0] o_data;
    logic       o_vld;
    logic       o_full;
    logic       o_empty;
    logic       o_ovf;
    logic [4:0] o_count;

    int n_cmp;
    int n_err;
    int cyc;
    int dbl;
    logic prev_vld;
    logic [7:0] q_data[$];
    int         q_cyc[$];

    uart_tx_fifo #(
        .FREQ     (50_000_000),
        .RATE     (2_000_000),
        .DEPTH    (16),
        .GAP_BITS (1)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .i_data  (i_data),
        .i_vld   (i_vld),
        .o_data  (o_data),
        .o_vld   (o_vld),
        .o_full  (o_full),
        .o_empty (o_empty),
        .o_ovf   (o_ovf),
        .o_count (o_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Log every output strobe with the cycle it was seen in.
    initial begin
        dbl = 0;
        prev_vld = 1'b0;
    end
    always @(negedge clk) begin
        if (o_vld === 1'b1) begin
            q_data.push_back(o_data);
            q_cyc.push_back(cyc);
            if (prev_vld === 1'b1) dbl = dbl + 1;
        end
        prev_vld = o_vld;
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic write_byte(input logic [7:0] b);
        i_data = b;
        i_vld  = 1'b1;
        step();
        i_vld  = 1'b0;
    endtask

    task automatic clear_log();
        q_data.delete();
        q_cyc.delete();
    endtask

    task automatic test_reset();
        rst    = 1'b1;
        i_vld  = 1'b1;
        i_data = 8'hFF;
        step();
        step();
        i_vld = 1'b0;
        n_cmp++; if (o_vld !== 1'b0)    begin n_err++; $display("FAIL reset_vld got %b want 0", o_vld); end
        n_cmp++; if (o_data !== 8'h00)  begin n_err++; $display("FAIL reset_data got %h want 00", o_data); end
        n_cmp++; if (o_count !== 5'd0)  begin n_err++; $display("FAIL reset_count got %0d want 0", o_count); end
        n_cmp++; if (o_empty !== 1'b1)  begin n_err++; $display("FAIL reset_empty got %b want 1", o_empty); end
        n_cmp++; if (o_full !== 1'b0)   begin n_err++; $display("FAIL reset_full got %b want 0", o_full); end
        n_cmp++; if (o_ovf !== 1'b0)    begin n_err++; $display("FAIL reset_ovf got %b want 0", o_ovf); end
        rst = 1'b0;
        step();
        n_cmp++; if (o_count !== 5'd0)  begin n_err++; $display("FAIL reset_ignores_write got %0d want 0", o_count); end
    endtask

    task automatic test_single();
        int k;
        repeat (5) step();
        clear_log();
        k = cyc;
        write_byte(8'hA5);
        repeat (10) step();
        n_cmp++;
        if (q_cyc.size() !== 1) begin
            n_err++; $display("FAIL single_pulses got %0d want 1", q_cyc.size());
        end else begin
            n_cmp++; if (q_cyc[0] !== k + 2)   begin n_err++; $display("FAIL single_latency got %0d want %0d", q_cyc[0], k + 2); end
            n_cmp++; if (q_data[0] !== 8'hA5)  begin n_err++; $display("FAIL single_data got %h want a5", q_data[0]); end
        end
        n_cmp++; if (o_empty !== 1'b1) begin n_err++; $display("FAIL single_empty got %b want 1", o_empty); end
        repeat (300) step();
    endtask

    task automatic test_burst();
        int k;
        int t;
        int peak;
        clear_log();
        peak = 0;
        k = cyc;
        for (int i = 0; i < 4; i++) begin
            write_byte(8'(i + 1));
            if (int'(o_count) > peak) peak = int'(o_count);
        end
        t = 0;
        while (q_cyc.size() < 4 && t < 1000) begin
            step();
            t++;
            if (int'(o_count) > peak) peak = int'(o_count);
        end
        n_cmp++;
        if (q_cyc.size() !== 4) begin
            n_err++; $display("FAIL burst_pulses got %0d want 4", q_cyc.size());
        end else begin
            for (int i = 0; i < 4; i++) begin
                n_cmp++;
                if (q_cyc[i] !== k + 2 + FRAME * i) begin
                    n_err++; $display("FAIL burst_time[%0d] got %0d want %0d", i, q_cyc[i], k + 2 + FRAME * i);
                end
                n_cmp++;
                if (q_data[i] !== 8'(i + 1)) begin
                    n_err++; $display("FAIL burst_data[%0d] got %h want %h", i, q_data[i], 8'(i + 1));
                end
            end
        end
        n_cmp++; if (peak !== 3) begin n_err++; $display("FAIL burst_peak_count got %0d want 3", peak); end
        repeat (300) step();
    endtask

    task automatic test_overflow();
        int k;
        int t;
        int first;
        clear_log();
        first = -1;
        k = cyc;
        for (int i = 0; i < 20; i++) begin
            write_byte(8'(i));
            if (o_ovf === 1'b1 && first < 0) first = cyc;
        end
        n_cmp++; if (first !== k + 18) begin n_err++; $display("FAIL ovf_rise_cycle got %0d want %0d", first, k + 18); end
        t = 0;
        while (q_cyc.size() < 17 && t < 5200) begin
            step();
            t++;
        end
        repeat (300) step();
        n_cmp++;
        if (q_data.size() !== 17) begin
            n_err++; $display("FAIL ovf_pulses got %0d want 17", q_data.size());
        end else begin
            for (int i = 0; i < 17; i++) begin
                n_cmp++;
                if (q_data[i] !== 8'(i)) begin
                    n_err++; $display("FAIL ovf_data[%0d] got %h want %h", i, q_data[i], 8'(i));
                end
            end
        end
        n_cmp++; if (o_ovf !== 1'b1) begin n_err++; $display("FAIL ovf_sticky got %b want 1", o_ovf); end
        rst = 1'b1;
        step();
        rst = 1'b0;
        n_cmp++; if (o_ovf !== 1'b0) begin n_err++; $display("FAIL ovf_clear got %b want 0", o_ovf); end
        step();
    endtask

    task automatic test_push_pop();
        int k;
        int t;
        clear_log();
        k = cyc;
        write_byte(8'h5A);
        n_cmp++; if (o_count !== 5'd1) begin n_err++; $display("FAIL pp_count_before got %0d want 1", o_count); end
        write_byte(8'hC3);
        n_cmp++; if (o_vld !== 1'b1)   begin n_err++; $display("FAIL pp_vld got %b want 1", o_vld); end
        n_cmp++; if (o_count !== 5'd1) begin n_err++; $display("FAIL pp_count_after got %0d want 1", o_count); end
        t = 0;
        while (q_cyc.size() < 2 && t < 400) begin
            step();
            t++;
        end
        n_cmp++;
        if (q_cyc.size() !== 2) begin
            n_err++; $display("FAIL pp_pulses got %0d want 2", q_cyc.size());
        end else begin
            n_cmp++; if (q_cyc[1] !== k + 2 + FRAME) begin n_err++; $display("FAIL pp_time got %0d want %0d", q_cyc[1], k + 2 + FRAME); end
            n_cmp++; if (q_data[1] !== 8'hC3)        begin n_err++; $display("FAIL pp_data got %h want c3", q_data[1]); end
        end
        repeat (300) step();
    endtask

    task automatic test_reset_wait();
        int k;
        int k2;
        clear_log();
        k = cyc;
        for (int i = 0; i < 4; i++) write_byte(8'(8'h71 + i));
        repeat (98) step();
        rst    = 1'b1;
        i_vld  = 1'b1;
        i_data = 8'hEE;
        step();
        rst   = 1'b0;
        i_vld = 1'b0;
        n_cmp++; if (o_count !== 5'd0) begin n_err++; $display("FAIL rw_count got %0d want 0", o_count); end
        n_cmp++; if (o_vld !== 1'b0)   begin n_err++; $display("FAIL rw_vld got %b want 0", o_vld); end
        n_cmp++; if (o_ovf !== 1'b0)   begin n_err++; $display("FAIL rw_ovf got %b want 0", o_ovf); end
        n_cmp++; if (q_cyc.size() !== 1 || q_cyc[0] !== k + 2) begin
            n_err++; $display("FAIL rw_pre_pulses got %0d want 1", q_cyc.size());
        end
        clear_log();
        repeat (3) step();
        k2 = cyc;
        write_byte(8'h3C);
        repeat (400) step();
        n_cmp++;
        if (q_cyc.size() !== 1) begin
            n_err++; $display("FAIL rw_post_pulses got %0d want 1", q_cyc.size());
        end else begin
            n_cmp++; if (q_cyc[0] !== k2 + 2)  begin n_err++; $display("FAIL rw_latency got %0d want %0d", q_cyc[0], k2 + 2); end
            n_cmp++; if (q_data[0] !== 8'h3C)  begin n_err++; $display("FAIL rw_data got %h want 3c", q_data[0]); end
        end
    endtask

    task automatic test_wrap();
        int peak;
        int bad_gap;
        int bad_data;
        clear_log();
        peak = 0;
        for (int g = 0; g < 8; g++) begin
            for (int j = 0; j < 5; j++) begin
                write_byte(8'(8'h20 + g * 5 + j));
                if (int'(o_count) > peak) peak = int'(o_count);
            end
            for (int t = 0; t < 1395; t++) begin
                step();
                if (int'(o_count) > peak) peak = int'(o_count);
            end
        end
        n_cmp++;
        if (q_data.size() !== 40) begin
            n_err++; $display("FAIL wrap_pulses got %0d want 40", q_data.size());
        end else begin
            bad_data = 0;
            bad_gap  = 0;
            for (int i = 0; i < 40; i++) begin
                if (q_data[i] !== 8'(8'h20 + i)) bad_data++;
                if ((i % 5) != 0 && (q_cyc[i] - q_cyc[i-1]) !== FRAME) bad_gap++;
            end
            n_cmp++; if (bad_data !== 0) begin n_err++; $display("FAIL wrap_order got %0d bad bytes want 0", bad_data); end
            n_cmp++; if (bad_gap !== 0)  begin n_err++; $display("FAIL wrap_spacing got %0d bad gaps want 0", bad_gap); end
        end
        n_cmp++; if (o_ovf !== 1'b0) begin n_err++; $display("FAIL wrap_ovf got %b want 0", o_ovf); end
        n_cmp++; if (peak !== 4)     begin n_err++; $display("FAIL wrap_peak_count got %0d want 4", peak); end
        n_cmp++; if (dbl !== 0)      begin n_err++; $display("FAIL back_to_back_vld got %0d want 0", dbl); end
    endtask

    initial begin
        n_cmp  = 0;
        n_err  = 0;
        rst    = 1'b1;
        i_vld  = 1'b0;
        i_data = 8'h00;
        test_reset();
        test_single();
        test_burst();
        test_overflow();
        test_push_pop();
        test_reset_wait();
        test_wrap();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
`default_nettype wire
